layer_seq_controller: RTL and testbench
=======================================

// Module: layer_seq_controller
// PURPOSE
//  Sequencer for one fully-connected layer: Q neurons x D inputs, processed P neurons per pass.
//  Drives input/weight fetch addresses, accumulator clear/write, optional bias cycle,
//  result write with lane mask and optional activation. Stalls on memory data_valid.
//  Sits between top-level start/done handshake and the MAC datapath and result buffer.
// PARAMETERS
//  N   8  datapath word width (carried for datapath consistency; no N-wide controller ports)
//  D   4  inputs per neuron, >=1
//  Q   6  neurons in layer, >=1
//  P   4  parallel MAC lanes, >=1
//  localparams: G=ceil(Q/P) groups; DW=max(1,$clog2(D)); GW=max(1,$clog2(G));
//               WW=max(1,$clog2(G*D)); RW=max(1,$clog2(Q))
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-low (0 = reset)
//  st          in   1   start request; sampled only in IDLE
//  bias_mode   in   1   1 = add one bias cycle per group; latched at start
//  act_mode    in   1   1 = activation applied on result write; latched at start
//  data_valid  in   1   fetched x/w words valid this cycle
//  rd_en       out  1   fetch request to x/w memories
//  x_addr      out  DW  input-vector index d
//  w_addr      out  WW  weight row index g*D+d
//  clear_acc   out  1   zero all P accumulators
//  acc_write   out  1   accumulate current product (or bias) into accumulators
//  bias_sel    out  1   accumulate bias instead of x*w
//  res_write   out  1   write P lane results to result buffer
//  res_idx     out  RW  first neuron index of current group (g*P)
//  lane_mask   out  P   valid lanes for res_write; 1s in LSBs
//  act_en      out  1   activation enable qualified with res_write
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle pulse at layer completion
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, d_cnt=0, g_cnt=0, latched modes=0; all outputs 0.
//  All outputs are decoded from state and counters (Moore); no output depends on st/data_valid.
//  States:
//   IDLE : st=1 -> CLR; latch bias_mode/act_mode; g_cnt=0. st=0 -> stay.
//   CLR  : clear_acc=1; d_cnt<=0 -> FETCH.
//   FETCH: rd_en=1; x_addr=d_cnt; w_addr=g_cnt*D+d_cnt. data_valid=1 -> MAC, else stay
//          (addresses held stable during stall; no stall timeout).
//   MAC  : acc_write=1. d_cnt==D-1 -> BIAS if bias latched, else WRITE; otherwise
//          d_cnt<=d_cnt+1 -> FETCH.
//   BIAS : acc_write=1, bias_sel=1, one cycle -> WRITE.
//   WRITE: res_write=1; res_idx=g_cnt*P; act_en=act latched;
//          lane_mask=all ones, except last group: low (Q-(G-1)*P) bits set.
//          g_cnt==G-1 -> DONE; else g_cnt<=g_cnt+1 -> CLR.
//   DONE : done=1 one cycle -> IDLE.
//  Per-group cycles with no stalls: 2D+2 (+1 if bias). Layer: done high in cycle
//   G*(2D+2+b)+1 counting the cycle after the st-sampling edge as cycle 1.
//  Each stall cycle (data_valid=0 in FETCH) adds exactly one cycle.
//  st while busy: ignored. st held high through DONE: new layer starts on next IDLE cycle.
//  bias_mode/act_mode changes while busy have no effect.
//  Reset mid-operation: immediate return to IDLE; no partial res_write or done.
//  D=1: FETCH/MAC once per group. G=1: g_cnt stays 0; lane_mask per last-group rule.
//  Counters never exceed D-1 / G-1; no wrap-around reachable.
// TESTING
//  1 D=4,Q=6,P=4, bias=0, act=0, data_valid=1: st pulse -> 2 groups; res_idx 0 then 4;
//    lane_mask 4'b1111 then 4'b0011; done high in cycle 21; busy low after.
//  2 Same, bias=1, act=1: BIAS after each 4th MAC with bias_sel=1; act_en=1 on both writes;
//    done in cycle 23.
//  3 data_valid=0 for 3 cycles at d=2 of group 0: rd_en, x_addr=2, w_addr=2 held; no acc_write;
//    done delayed by exactly 3 cycles.
//  4 rst=0 asserted mid-MAC of group 1: all outputs 0 immediately; after release, st restarts
//    at g=0 and completes normally.
//  5 st held high continuously: back-to-back layers; st pulses during busy ignored;
//    exactly one done per layer.
//  6 D=1,Q=1,P=1: CLR,FETCH,MAC,WRITE,DONE; lane_mask=1'b1; done in cycle 5.

Source files
------------

// File: rtl/layer_seq_controller.sv
// Sequencer for one fully-connected layer: walks G groups of P neurons over D inputs,
// issuing fetch, accumulate, optional bias, and result-write strobes with a done pulse.
module layer_seq_controller #(
  parameter  int N  = 8,
  parameter  int D  = 4,
  parameter  int Q  = 6,
  parameter  int P  = 4,
  localparam int G  = (Q + P - 1) / P,
  localparam int DW = (D > 1) ? $clog2(D) : 1,
  localparam int GW = (G > 1) ? $clog2(G) : 1,
  localparam int WW = ((G * D) > 1) ? $clog2(G * D) : 1,
  localparam int RW = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          bias_mode,
  input  logic          act_mode,
  input  logic          data_valid,
  output logic          rd_en,
  output logic [DW-1:0] x_addr,
  output logic [WW-1:0] w_addr,
  output logic          clear_acc,
  output logic          acc_write,
  output logic          bias_sel,
  output logic          res_write,
  output logic [RW-1:0] res_idx,
  output logic [P-1:0]  lane_mask,
  output logic          act_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FETCH = 3'd2,
    MAC   = 3'd3,
    BIAS  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Lanes valid in the final group: the low (Q - (G-1)*P) bits.
  function automatic logic [P-1:0] low_ones(input int n);
    logic [P-1:0] m;
    m = {P{1'b0}};
    for (int i = 0; i < P; i++) begin
      if (i < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  localparam logic [P-1:0]  LAST_MASK = low_ones(Q - (G - 1) * P);
  localparam logic [DW-1:0] D_LAST    = DW'(D - 1);
  localparam logic [GW-1:0] G_LAST    = GW'(G - 1);

  if (N < 1 || D < 1 || Q < 1 || P < 1) begin : g_param_check
    $error("layer_seq_controller: N, D, Q and P must all be >= 1");
  end

  state_t          state_r, state_nx;
  logic [DW-1:0]   d_cnt_r, d_nx;
  logic [GW-1:0]   g_cnt_r, g_nx;
  logic            bias_r, bias_nx;
  logic            act_r, act_nx;

  logic            rd_en_nx, clear_acc_nx, acc_write_nx, bias_sel_nx;
  logic            res_write_nx, act_en_nx, busy_nx, done_nx;
  logic [DW-1:0]   x_addr_nx;
  logic [WW-1:0]   w_addr_nx;
  logic [RW-1:0]   res_idx_nx;
  logic [P-1:0]    lane_mask_nx;

  // State, counters, latched modes and registered output strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      d_cnt_r   <= {DW{1'b0}};
      g_cnt_r   <= {GW{1'b0}};
      bias_r    <= 1'b0;
      act_r     <= 1'b0;
      rd_en     <= 1'b0;
      x_addr    <= {DW{1'b0}};
      w_addr    <= {WW{1'b0}};
      clear_acc <= 1'b0;
      acc_write <= 1'b0;
      bias_sel  <= 1'b0;
      res_write <= 1'b0;
      res_idx   <= {RW{1'b0}};
      lane_mask <= {P{1'b0}};
      act_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nx;
      d_cnt_r   <= d_nx;
      g_cnt_r   <= g_nx;
      bias_r    <= bias_nx;
      act_r     <= act_nx;
      rd_en     <= rd_en_nx;
      x_addr    <= x_addr_nx;
      w_addr    <= w_addr_nx;
      clear_acc <= clear_acc_nx;
      acc_write <= acc_write_nx;
      bias_sel  <= bias_sel_nx;
      res_write <= res_write_nx;
      res_idx   <= res_idx_nx;
      lane_mask <= lane_mask_nx;
      act_en    <= act_en_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_nx = state_r;
    d_nx     = d_cnt_r;
    g_nx     = g_cnt_r;
    bias_nx  = bias_r;
    act_nx   = act_r;
    case (state_r)
      IDLE: begin
        if (st) begin
          state_nx = CLR;
          bias_nx  = bias_mode;
          act_nx   = act_mode;
          g_nx     = {GW{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      CLR: begin
        d_nx     = {DW{1'b0}};
        state_nx = FETCH;
      end
      FETCH: begin
        if (data_valid) begin
          state_nx = MAC;
        end else begin
          state_nx = FETCH;
        end
      end
      MAC: begin
        if (d_cnt_r == D_LAST) begin
          if (bias_r) begin
            state_nx = BIAS;
          end else begin
            state_nx = WRITE;
          end
        end else begin
          d_nx     = d_cnt_r + DW'(1);
          state_nx = FETCH;
        end
      end
      BIAS: begin
        state_nx = WRITE;
      end
      WRITE: begin
        if (g_cnt_r == G_LAST) begin
          state_nx = DONE;
        end else begin
          g_nx     = g_cnt_r + GW'(1);
          state_nx = CLR;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        d_nx     = {DW{1'b0}};
        g_nx     = {GW{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies track the state register.
  always_comb begin
    rd_en_nx     = 1'b0;
    x_addr_nx    = {DW{1'b0}};
    w_addr_nx    = {WW{1'b0}};
    clear_acc_nx = 1'b0;
    acc_write_nx = 1'b0;
    bias_sel_nx  = 1'b0;
    res_write_nx = 1'b0;
    res_idx_nx   = {RW{1'b0}};
    lane_mask_nx = {P{1'b0}};
    act_en_nx    = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    case (state_nx)
      IDLE: begin
        busy_nx = 1'b0;
      end
      CLR: begin
        busy_nx      = 1'b1;
        clear_acc_nx = 1'b1;
      end
      FETCH: begin
        busy_nx   = 1'b1;
        rd_en_nx  = 1'b1;
        x_addr_nx = d_nx;
        w_addr_nx = WW'(g_nx) * WW'(D) + WW'(d_nx);
      end
      MAC: begin
        busy_nx      = 1'b1;
        acc_write_nx = 1'b1;
      end
      BIAS: begin
        busy_nx      = 1'b1;
        acc_write_nx = 1'b1;
        bias_sel_nx  = 1'b1;
      end
      WRITE: begin
        busy_nx      = 1'b1;
        res_write_nx = 1'b1;
        res_idx_nx   = RW'(g_nx) * RW'(P);
        act_en_nx    = act_nx;
        if (g_nx == G_LAST) begin
          lane_mask_nx = LAST_MASK;
        end else begin
          lane_mask_nx = {P{1'b1}};
        end
      end
      DONE: begin
        busy_nx = 1'b1;
        done_nx = 1'b1;
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_layer_seq_controller.sv
// Bench for layer_seq_controller: an expected event stream per layer (stall-aware) is
// compared cycle by cycle against a D=4,Q=6,P=4 instance; a D=1,Q=1,P=1 instance is checked directly.
module tb_layer_seq_controller;

  localparam int A_D = 4;
  localparam int A_Q = 6;
  localparam int A_P = 4;
  localparam int A_G = (A_Q + A_P - 1) / A_P;

  localparam int K_IDLE  = 0;
  localparam int K_CLR   = 1;
  localparam int K_FETCH = 2;
  localparam int K_MAC   = 3;
  localparam int K_BIAS  = 4;
  localparam int K_WRITE = 5;
  localparam int K_DONE  = 6;

  typedef struct {
    int k;
    int g;
    int d;
  } rec_t;

  logic clk = 1'b0;
  logic rst, st, b_st, bias_mode, act_mode, dv;

  logic       a_rd, a_clr, a_acc, a_bsel, a_resw, a_act, a_busy, a_done;
  logic [1:0] a_x;
  logic [2:0] a_w;
  logic [2:0] a_ridx;
  logic [3:0] a_mask;

  logic b_rd, b_clr, b_acc, b_bsel, b_resw, b_act, b_busy, b_done;
  logic b_x, b_w, b_ridx, b_mask;

  int checks = 0;
  int errors = 0;
  int a_dones = 0;

  always #5 clk = ~clk;

  layer_seq_controller #(.N(8), .D(A_D), .Q(A_Q), .P(A_P)) dut_a (
    .clk(clk), .rst(rst), .st(st), .bias_mode(bias_mode), .act_mode(act_mode),
    .data_valid(dv), .rd_en(a_rd), .x_addr(a_x), .w_addr(a_w), .clear_acc(a_clr),
    .acc_write(a_acc), .bias_sel(a_bsel), .res_write(a_resw), .res_idx(a_ridx),
    .lane_mask(a_mask), .act_en(a_act), .busy(a_busy), .done(a_done)
  );

  layer_seq_controller #(.N(8), .D(1), .Q(1), .P(1)) dut_b (
    .clk(clk), .rst(rst), .st(b_st), .bias_mode(bias_mode), .act_mode(act_mode),
    .data_valid(dv), .rd_en(b_rd), .x_addr(b_x), .w_addr(b_w), .clear_acc(b_clr),
    .acc_write(b_acc), .bias_sel(b_bsel), .res_write(b_resw), .res_idx(b_ridx),
    .lane_mask(b_mask), .act_en(b_act), .busy(b_busy), .done(b_done)
  );

  always @(negedge clk) begin
    if (a_done === 1'b1) a_dones <= a_dones + 1;
  end

  function automatic logic [19:0] a_obs();
    return {a_rd, a_x, a_w, a_clr, a_acc, a_bsel, a_resw, a_ridx, a_mask, a_act, a_busy, a_done};
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp,
                     input logic [19:0] care);
    checks++;
    assert (((obs ^ exp) & care) === 20'd0)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h care=%h", tag, obs, exp, care);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs of instance A for one event, from the layer rules.
  task automatic check_a(input rec_t r, input bit a, input string tag);
    logic [19:0] e, c;
    logic        fe, wr;
    int          m;
    fe = (r.k == K_FETCH);
    wr = (r.k == K_WRITE);
    m  = (r.g == A_G - 1) ? (1 << (A_Q - (A_G - 1) * A_P)) - 1 : (1 << A_P) - 1;
    e  = {fe, 2'(r.d), 3'(r.g * A_D + r.d), r.k == K_CLR, (r.k == K_MAC) || (r.k == K_BIAS),
          r.k == K_BIAS, wr, 3'(r.g * A_P), 4'(m), wr && a, r.k != K_IDLE, r.k == K_DONE};
    c  = {1'b1, {2{fe}}, {3{fe}}, 4'hF, {3{wr}}, {4{wr}}, 3'b111};
    chk($sformatf("%s k=%0d g=%0d d=%0d", tag, r.k, r.g, r.d), a_obs(), e, c);
  endtask

  // Precondition: at a negedge of an IDLE cycle. Returns at the negedge of the following IDLE cycle.
  // stall_mode: 0 random stalls, 1 none, 2 three stalls at g=0 d=2.
  task automatic run_layer(input bit b, input bit a, input bit hold, input int stall_mode,
                           input int abort_g, input int exp_done);
    rec_t q[$];
    rec_t r;
    int   cyc = 0, stalls = 0, dir = 0, want;
    bit   dvv;
    for (int g = 0; g < A_G; g++) begin
      q.push_back('{K_CLR, g, 0});
      for (int d = 0; d < A_D; d++) begin
        q.push_back('{K_FETCH, g, d});
        q.push_back('{K_MAC, g, d});
      end
      if (b) q.push_back('{K_BIAS, g, 0});
      q.push_back('{K_WRITE, g, 0});
    end
    q.push_back('{K_DONE, 0, 0});
    st = 1'b1; bias_mode = b; act_mode = a; dv = 1'($urandom % 2);
    while (q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        chk_int("timeout", cyc, 0);
        q.delete();
        break;
      end
      r = q[0];
      check_a(r, a, "cyc");
      if (r.k == K_DONE) begin
        want = (exp_done >= 0) ? exp_done : A_G * (2 * A_D + 2 + int'(b)) + 1 + stalls;
        chk_int("done_cycle", cyc, want);
      end
      if (abort_g >= 0 && r.k == K_MAC && r.g == abort_g && r.d == 1) begin
        rst = 1'b0; st = 1'b0;
        #1;
        chk("rst_async_a", a_obs(), 20'd0, 20'hFFFFF);
        chk("rst_async_b", {8'd0, b_rd, b_x, b_w, b_clr, b_acc, b_bsel, b_resw, b_ridx, b_mask,
            b_act, b_busy, b_done}, 20'd0, 20'hFFFFF);
        repeat (2) begin
          @(negedge clk);
          chk("rst_hold", a_obs(), 20'd0, 20'hFFFFF);
        end
        rst = 1'b1;
        return;
      end
      if (r.k == K_FETCH) begin
        case (stall_mode)
          0: dvv = ($urandom % 4) != 0;
          1: dvv = 1'b1;
          default: begin
            dvv = !(r.g == 0 && r.d == 2 && dir < 3);
            if (!dvv) dir++;
          end
        endcase
      end else begin
        dvv = 1'($urandom % 2);
      end
      dv = dvv;
      st = hold ? 1'b1 : 1'($urandom % 2);
      bias_mode = 1'($urandom % 2);
      act_mode  = 1'($urandom % 2);
      if (r.k == K_FETCH && !dvv) stalls++;
      else void'(q.pop_front());
    end
    @(negedge clk);
    check_a('{K_IDLE, 0, 0}, a, "idle_after");
    st = hold;
  endtask

  initial begin
    int   d0;
    int   kinds[6];
    logic e_b;
    rst = 1'b0; st = 1'b0; b_st = 1'b0; bias_mode = 1'b0; act_mode = 1'b0; dv = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", a_obs(), 20'd0, 20'hFFFFF);
    chk("reset_b", {8'd0, b_rd, b_x, b_w, b_clr, b_acc, b_bsel, b_resw, b_ridx, b_mask,
        b_act, b_busy, b_done}, 20'd0, 20'hFFFFF);
    rst = 1'b1;
    @(negedge clk);
    check_a('{K_IDLE, 0, 0}, 1'b0, "idle_start");

    // 1: plain layer, 2: bias+activation, 3: directed three-cycle stall.
    run_layer(1'b0, 1'b0, 1'b0, 1, -1, 21);
    run_layer(1'b1, 1'b1, 1'b0, 1, -1, 23);
    run_layer(1'b0, 1'b0, 1'b0, 2, -1, 24);

    // Randomised modes and stalls.
    for (int i = 0; i < 6; i++) begin
      run_layer(1'($urandom % 2), 1'($urandom % 2), 1'b0, 0, -1, -1);
    end

    // 4: reset mid-MAC of group 1, then a clean restart.
    run_layer(1'b1, 1'b0, 1'b0, 1, 1, -1);
    check_a('{K_IDLE, 0, 0}, 1'b0, "idle_after_rst");
    run_layer(1'b0, 1'b1, 1'b0, 0, -1, -1);

    // 5: st held high, back-to-back layers.
    d0 = a_dones;
    run_layer(1'b0, 1'b1, 1'b1, 1, -1, 21);
    run_layer(1'b1, 1'b0, 1'b1, 0, -1, -1);
    run_layer(1'b0, 1'b0, 1'b1, 1, -1, 21);
    st = 1'b0;
    @(negedge clk);
    check_a('{K_IDLE, 0, 0}, 1'b0, "idle_no_restart");
    chk_int("done_count", a_dones - d0, 3);

    // 6: D=1,Q=1,P=1 instance: CLR, FETCH, MAC, WRITE, DONE, then IDLE.
    kinds = '{K_CLR, K_FETCH, K_MAC, K_WRITE, K_DONE, K_IDLE};
    dv = 1'b1; bias_mode = 1'b0; act_mode = 1'b0; b_st = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_st = 1'b0;
      e_b = (kinds[i] == K_WRITE);
      chk($sformatf("small cyc=%0d", i + 1),
          {8'd0, b_rd, b_x, b_w, b_clr, b_acc, b_bsel, b_resw, b_ridx, b_mask, b_act, b_busy, b_done},
          {8'd0, kinds[i] == K_FETCH, 1'b0, 1'b0, kinds[i] == K_CLR, kinds[i] == K_MAC, 1'b0, e_b,
           1'b0, e_b, 1'b0, kinds[i] != K_IDLE, kinds[i] == K_DONE},
          20'h00FFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
